multi_issue_scheduler: RTL and testbench

- Next-generation queue scheduler for MemorEDF.
- Arbitrates NUMBER_OF_QUEUES request queues onto one memory port under a runtime-selected policy: round-robin, fixed-priority, budget-regulated fixed-priority or TDMA.
- Unlike the single-transaction scheduler, it issues grants through a valid/ready handshake and keeps up to MAX_OUTSTANDING transactions in flight. Completions retire in order to per-queue consumed pulses.
- Sits between the queue bank and the AXI dispatcher.

---
 rtl/memoredf_sched_pkg.sv | 19 +
 rtl/sched_id_fifo.sv | 71 +++++++
 rtl/multi_issue_scheduler.sv | 274 +++++++++++++++++++++++++++
 tb/tb_multi_issue_scheduler.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/memoredf_sched_pkg.sv
// Shared types and width helpers for the MemorEDF multi-issue scheduler.
package memoredf_sched_pkg;

    typedef enum logic [1:0] {
        SCHED_RR     = 2'd0,
        SCHED_FP     = 2'd1,
        SCHED_BUDGET = 2'd2,
        SCHED_TDMA   = 2'd3
    } sched_mode_t;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int count_width(input int m);
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sched_id_fifo.sv
// Synchronous FIFO of granted queue IDs; supports push and pop in the same cycle.
module sched_id_fifo
    import memoredf_sched_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            push,
    input  logic [WIDTH-1:0]                push_id,
    input  logic                            pop,
    output logic [WIDTH-1:0]                head_id,
    output logic                            full,
    output logic                            empty,
    output logic [count_width(DEPTH)-1:0]   count
);

    localparam int PTR_W = id_width(DEPTH);
    localparam int CNT_W = count_width(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push_s, do_pop_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? {PTR_W{1'b0}} : p + PTR_W'(1);
    endfunction

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == {CNT_W{1'b0}});
    assign count   = count_q;
    assign head_id = mem_q[rd_ptr_q];

    // A push into a full FIFO is legal only when a pop frees the head in the same cycle.
    always_comb begin
        do_pop_s  = pop & ~empty;
        do_push_s = push & (~full | do_pop_s);
        wr_ptr_d  = do_push_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d  = do_pop_s ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy state.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage; contents are don't-care while the FIFO is empty.
    always_ff @(posedge clock) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= push_id;
        end
    end

endmodule

// File: rtl/multi_issue_scheduler.sv
// Multi-issue queue scheduler: RR / FP / budget-regulated FP / TDMA arbitration with valid/ready grants.
// Optional per-queue grant counters when MULTI_ISSUE_SCHEDULER_STATS_EN is defined.
module multi_issue_scheduler
    import memoredf_sched_pkg::*;
#(
    parameter int NUMBER_OF_QUEUES = 4,
    parameter int REGISTER_SIZE    = 32,
    parameter int PRIORITY_SIZE    = 4,
    parameter int MAX_OUTSTANDING  = 4
) (
    input  logic                                            clock,
    input  logic                                            reset,
    input  logic [1:0]                                      mode,
    input  logic [NUMBER_OF_QUEUES-1:0]                     empty,
    input  logic [NUMBER_OF_QUEUES-1:0][PRIORITY_SIZE-1:0]  priorities,
    input  logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0]  budgets,
    input  logic [REGISTER_SIZE-1:0]                        period,
    input  logic [REGISTER_SIZE-1:0]                        slot_length,
    output logic                                            grant_valid,
    output logic [id_width(NUMBER_OF_QUEUES)-1:0]           grant_id,
    input  logic                                            grant_ready,
    input  logic                                            done,
    output logic [NUMBER_OF_QUEUES-1:0]                     consumed,
    output logic [count_width(MAX_OUTSTANDING)-1:0]         outstanding,
    output logic [NUMBER_OF_QUEUES-1:0]                     budget_exhausted,
    output logic                                            protocol_error
`ifdef MULTI_ISSUE_SCHEDULER_STATS_EN
    ,
    input  logic                                            stats_clear,
    output logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0]  grant_count
`endif
);

    localparam int N     = NUMBER_OF_QUEUES;
    localparam int R     = REGISTER_SIZE;
    localparam int ID_W  = id_width(N);
    localparam int CNT_W = count_width(MAX_OUTSTANDING);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(N - 1);
    localparam logic [R-1:0]    ZERO_R  = {R{1'b0}};
    localparam logic [R-1:0]    ONE_R   = R'(1);

    logic                  grant_valid_q, grant_valid_d;
    logic [ID_W-1:0]       grant_id_q, grant_id_d;
    logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
    sched_mode_t           mode_q, mode_d;
    logic [ID_W-1:0]       owner_q, owner_d;
    logic [R-1:0]          slot_cnt_q, slot_cnt_d;
    logic [R-1:0]          slot_len_q, slot_len_d;
    logic [R-1:0]          period_cnt_q, period_cnt_d;
    logic [R-1:0]          period_len_q, period_len_d;
    logic [N-1:0][R-1:0]   remaining_q, remaining_d;
    logic [N-1:0]          consumed_q, consumed_d;
    logic [N-1:0]          budget_exh_q, budget_exh_d;
    logic                  protocol_error_q, protocol_error_d;

    logic [N-1:0]          eligible_s;
    logic [ID_W-1:0]       winner_s;
    logic                  handshake_s, done_pop_s, reload_s;
    logic [R-1:0]          slot_last_s;
    logic [ID_W-1:0]       fifo_head_s;
    logic                  fifo_full_s, fifo_empty_s;
    logic [CNT_W-1:0]      fifo_count_s;

    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        return (id == LAST_ID) ? {ID_W{1'b0}} : id + ID_W'(1);
    endfunction

    function automatic logic [ID_W-1:0] rr_pick(input logic [N-1:0] elig,
                                                input logic [ID_W-1:0] start);
        logic [ID_W-1:0] idx;
        logic [ID_W-1:0] pick;
        logic            found;
        idx   = start;
        pick  = start;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && elig[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
            idx = next_id(idx);
        end
        return pick;
    endfunction

    // Strict '>' keeps the lowest index on priority ties.
    function automatic logic [ID_W-1:0] fp_pick(input logic [N-1:0] elig,
                                                input logic [N-1:0][PRIORITY_SIZE-1:0] prio);
        logic [ID_W-1:0]          pick;
        logic [PRIORITY_SIZE-1:0] best;
        logic                     found;
        pick  = {ID_W{1'b0}};
        best  = {PRIORITY_SIZE{1'b0}};
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (elig[i] && (!found || prio[i] > best)) begin
                pick  = ID_W'(i);
                best  = prio[i];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign done_pop_s  = done & ~fifo_empty_s;
    assign handshake_s = grant_valid_q & grant_ready & (~fifo_full_s | done_pop_s);

    sched_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (ID_W)
    ) u_id_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (handshake_s),
        .push_id (grant_id_q),
        .pop     (done),
        .head_id (fifo_head_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .count   (fifo_count_s)
    );

    // Eligibility and winner selection for the registered mode.
    always_comb begin
        eligible_s = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            case (mode_q)
                SCHED_BUDGET: eligible_s[i] = ~empty[i] & ((remaining_q[i] != ZERO_R) | (period == ZERO_R));
                SCHED_TDMA:   eligible_s[i] = ~empty[i] & (owner_q == ID_W'(i));
                default:      eligible_s[i] = ~empty[i];
            endcase
        end
        case (mode_q)
            SCHED_RR:   winner_s = rr_pick(eligible_s, rr_ptr_q);
            SCHED_TDMA: winner_s = owner_q;
            default:    winner_s = fp_pick(eligible_s, priorities);
        endcase
    end

    // Grant register, mode sampling, completion and error tracking.
    always_comb begin
        grant_valid_d = grant_valid_q;
        grant_id_d    = grant_id_q;
        rr_ptr_d      = rr_ptr_q;
        if (grant_valid_q) begin
            if (handshake_s) begin
                grant_valid_d = 1'b0;
                rr_ptr_d      = next_id(grant_id_q);
            end else begin
                grant_valid_d = 1'b1;
            end
        end else if ((|eligible_s) && !fifo_full_s) begin
            grant_valid_d = 1'b1;
            grant_id_d    = winner_s;
        end else begin
            grant_valid_d = 1'b0;
        end
        mode_d = (!grant_valid_q && fifo_empty_s) ? sched_mode_t'(mode) : mode_q;
        consumed_d = {N{1'b0}};
        if (done_pop_s) begin
            consumed_d[fifo_head_s] = 1'b1;
        end else begin
            consumed_d = {N{1'b0}};
        end
        protocol_error_d = protocol_error_q | (done & fifo_empty_s);
    end

    // TDMA slot timer, regulation period timer and remaining budgets.
    always_comb begin
        slot_len_d   = slot_length;
        owner_d      = owner_q;
        slot_last_s  = (slot_length == ZERO_R) ? ZERO_R : slot_length - ONE_R;
        if (slot_length != slot_len_q) begin
            slot_cnt_d = ZERO_R;
        end else if (slot_cnt_q >= slot_last_s) begin
            slot_cnt_d = ZERO_R;
            owner_d    = next_id(owner_q);
        end else begin
            slot_cnt_d = slot_cnt_q + ONE_R;
        end

        period_len_d = period;
        reload_s     = 1'b0;
        if ((period != period_len_q) || (period == ZERO_R)) begin
            period_cnt_d = ZERO_R;
        end else if (period_cnt_q >= period - ONE_R) begin
            period_cnt_d = ZERO_R;
            reload_s     = 1'b1;
        end else begin
            period_cnt_d = period_cnt_q + ONE_R;
        end

        remaining_d = remaining_q;
        if (reload_s) begin
            remaining_d = budgets;
        end else if (handshake_s && (mode_q == SCHED_BUDGET) && (remaining_q[grant_id_q] != ZERO_R)) begin
            remaining_d[grant_id_q] = remaining_q[grant_id_q] - ONE_R;
        end else begin
            remaining_d = remaining_q;
        end

        for (int i = 0; i < N; i++) begin
            budget_exh_d[i] = (mode_d == SCHED_BUDGET) && (remaining_d[i] == ZERO_R);
        end
    end

    // Scheduler state; reset drops everything in flight and captures the configuration.
    always_ff @(posedge clock) begin
        if (!reset) begin
            grant_valid_q    <= 1'b0;
            grant_id_q       <= {ID_W{1'b0}};
            rr_ptr_q         <= {ID_W{1'b0}};
            mode_q           <= sched_mode_t'(mode);
            owner_q          <= {ID_W{1'b0}};
            slot_cnt_q       <= ZERO_R;
            slot_len_q       <= slot_length;
            period_cnt_q     <= ZERO_R;
            period_len_q     <= period;
            remaining_q      <= budgets;
            consumed_q       <= {N{1'b0}};
            budget_exh_q     <= {N{1'b0}};
            protocol_error_q <= 1'b0;
        end else begin
            grant_valid_q    <= grant_valid_d;
            grant_id_q       <= grant_id_d;
            rr_ptr_q         <= rr_ptr_d;
            mode_q           <= mode_d;
            owner_q          <= owner_d;
            slot_cnt_q       <= slot_cnt_d;
            slot_len_q       <= slot_len_d;
            period_cnt_q     <= period_cnt_d;
            period_len_q     <= period_len_d;
            remaining_q      <= remaining_d;
            consumed_q       <= consumed_d;
            budget_exh_q     <= budget_exh_d;
            protocol_error_q <= protocol_error_d;
        end
    end

    assign grant_valid      = grant_valid_q;
    assign grant_id         = grant_id_q;
    assign consumed         = consumed_q;
    assign outstanding      = fifo_count_s;
    assign budget_exhausted = budget_exh_q;
    assign protocol_error   = protocol_error_q;

`ifdef MULTI_ISSUE_SCHEDULER_STATS_EN
    logic [N-1:0][R-1:0] grant_count_q, grant_count_d;

    // Saturating per-queue handshake counters; clear has precedence.
    always_comb begin
        grant_count_d = grant_count_q;
        if (stats_clear) begin
            grant_count_d = {(N*R){1'b0}};
        end else if (handshake_s && (grant_count_q[grant_id_q] != {R{1'b1}})) begin
            grant_count_d[grant_id_q] = grant_count_q[grant_id_q] + ONE_R;
        end else begin
            grant_count_d = grant_count_q;
        end
    end

    // Counter storage.
    always_ff @(posedge clock) begin
        if (!reset) begin
            grant_count_q <= {(N*R){1'b0}};
        end else begin
            grant_count_q <= grant_count_d;
        end
    end

    assign grant_count = grant_count_q;
`endif

endmodule

// File: tb/tb_multi_issue_scheduler.sv
// Directed-vector bench for multi_issue_scheduler (4 queues, 3 outstanding).
module tb_multi_issue_scheduler;

    localparam int N    = 4;
    localparam int R    = 32;
    localparam int P    = 4;
    localparam int MAXO = 3;

    logic                  clock = 1'b0;
    logic                  reset;
    logic [1:0]            mode;
    logic [N-1:0]          empty;
    logic [N-1:0][P-1:0]   priorities;
    logic [N-1:0][R-1:0]   budgets;
    logic [R-1:0]          period;
    logic [R-1:0]          slot_length;
    logic                  grant_valid;
    logic [1:0]            grant_id;
    logic                  grant_ready;
    logic                  done;
    logic [N-1:0]          consumed;
    logic [1:0]            outstanding;
    logic [N-1:0]          budget_exhausted;
    logic                  protocol_error;
`ifdef MULTI_ISSUE_SCHEDULER_STATS_EN
    logic                  stats_clear = 1'b0;
    logic [N-1:0][R-1:0]   grant_count;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic auto_done;
    int hs_id_q[$];
    int hs_cyc_q[$];
    logic [3:0] cons_q[$];

    always #5 clock = ~clock;

    multi_issue_scheduler #(
        .NUMBER_OF_QUEUES (N),
        .REGISTER_SIZE    (R),
        .PRIORITY_SIZE    (P),
        .MAX_OUTSTANDING  (MAXO)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .mode             (mode),
        .empty            (empty),
        .priorities       (priorities),
        .budgets          (budgets),
        .period           (period),
        .slot_length      (slot_length),
        .grant_valid      (grant_valid),
        .grant_id         (grant_id),
        .grant_ready      (grant_ready),
        .done             (done),
        .consumed         (consumed),
        .outstanding      (outstanding),
        .budget_exhausted (budget_exhausted),
        .protocol_error   (protocol_error)
`ifdef MULTI_ISSUE_SCHEDULER_STATS_EN
        ,
        .stats_clear      (stats_clear),
        .grant_count      (grant_count)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: log a handshake that the coming edge performs, then sample just after the edge.
    task automatic tick();
        logic hs;
        hs = grant_valid && grant_ready && ((outstanding < 2'd3) || done);
        if (hs) begin
            hs_id_q.push_back(int'(grant_id));
            hs_cyc_q.push_back(cyc);
        end
        @(posedge clock);
        #1;
        cyc++;
        done = auto_done ? hs : 1'b0;
        if (consumed != 4'b0000) cons_q.push_back(consumed);
    endtask

    task automatic do_reset(input logic [1:0] m);
        mode      = m;
        reset     = 1'b0;
        auto_done = 1'b0;
        done      = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        hs_id_q.delete();
        hs_cyc_q.delete();
        cons_q.delete();
        cyc = 0;
    endtask

    function automatic int hs_at(input int i);
        return (i < hs_id_q.size()) ? hs_id_q[i] : -1;
    endfunction

    initial begin
        int rr_exp[5];
        int bud_exp[9];
        logic [3:0] cons_exp[4];
        reset       = 1'b0;
        mode        = 2'd0;
        empty       = 4'hF;
        priorities  = {N*P{1'b0}};
        budgets     = {4{32'd2}};
        period      = 32'd0;
        slot_length = 32'd1;
        grant_ready = 1'b0;
        done        = 1'b0;
        auto_done   = 1'b0;

        // Reset state
        do_reset(2'd0);
        check_eq("rst_valid", {31'd0, grant_valid}, 32'd0);
        check_eq("rst_outstanding", {30'd0, outstanding}, 32'd0);
        check_eq("rst_consumed", {28'd0, consumed}, 32'd0);
        check_eq("rst_perr", {31'd0, protocol_error}, 32'd0);
        check_eq("rst_exh", {28'd0, budget_exhausted}, 32'd0);

        // Round robin with a done one cycle after each handshake
        empty = 4'h0; grant_ready = 1'b1;
        do_reset(2'd0);
        auto_done = 1'b1;
        repeat (12) tick();
        rr_exp = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5; i++) check_eq($sformatf("rr_id%0d", i), hs_at(i), rr_exp[i]);
        cons_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        for (int i = 0; i < 4; i++)
            check_eq($sformatf("rr_cons%0d", i), (i < cons_q.size()) ? {28'd0, cons_q[i]} : 32'hFFFF, {28'd0, cons_exp[i]});

        // Fixed priority, tie between queues 1 and 2
        priorities[0] = 4'd3; priorities[1] = 4'd7; priorities[2] = 4'd7; priorities[3] = 4'd1;
        do_reset(2'd1);
        auto_done = 1'b1;
        repeat (8) tick();
        for (int i = 0; i < 3; i++) check_eq($sformatf("fp_id%0d", i), hs_at(i), 1);
        empty[1] = 1'b1;
        repeat (8) tick();
        check_eq("fp_after_empty", hs_id_q[hs_id_q.size() - 1], 2);

        // Budget-regulated FP
        empty = 4'h0;
        priorities[0] = 4'd0; priorities[1] = 4'd0; priorities[2] = 4'd0; priorities[3] = 4'd9;
        period = 32'd20;
        do_reset(2'd2);
        auto_done = 1'b1;
        repeat (17) tick();
        check_eq("bud_exhausted_all", {28'd0, budget_exhausted}, 32'hF);
        repeat (9) tick();
        bud_exp = '{3, 3, 0, 0, 1, 1, 2, 2, 3};
        for (int i = 0; i < 9; i++) check_eq($sformatf("bud_id%0d", i), hs_at(i), bud_exp[i]);
        check_eq("bud_reload_wait", (hs_cyc_q.size() > 8 && hs_cyc_q[8] >= 20) ? 32'd1 : 32'd0, 32'd1);
        check_eq("bud_exh_q3", {28'd0, budget_exhausted}, 32'h8);
        period = 32'd0;

        // Held grant, fill to capacity, then one completion
        grant_ready = 1'b0;
        do_reset(2'd0);
        repeat (2) tick();
        empty[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("hold_valid%0d", i), {31'd0, grant_valid}, 32'd1);
            check_eq($sformatf("hold_id%0d", i), {30'd0, grant_id}, 32'd0);
            tick();
        end
        grant_ready = 1'b1;
        repeat (8) tick();
        check_eq("full_outstanding", {30'd0, outstanding}, 32'd3);
        check_eq("full_no_valid", {31'd0, grant_valid}, 32'd0);
        for (int i = 0; i < 3; i++) check_eq($sformatf("full_id%0d", i), hs_at(i), i);
        done = 1'b1;
        tick();
        check_eq("full_consumed", {28'd0, consumed}, 32'h1);
        repeat (4) tick();
        check_eq("full_next_id", hs_at(3), 3);

        // TDMA with only queue 2 backlogged
        empty = 4'b1011; slot_length = 32'd3; grant_ready = 1'b1;
        do_reset(2'd3);
        repeat (30) tick();
        check_eq("tdma_count", hs_id_q.size(), 3);
        for (int i = 0; i < 3 && i < hs_id_q.size(); i++) begin
            check_eq($sformatf("tdma_id%0d", i), hs_id_q[i], 2);
            check_eq($sformatf("tdma_win%0d", i),
                     ((hs_cyc_q[i] % 12) >= 6 && (hs_cyc_q[i] % 12) <= 9) ? 32'd1 : 32'd0, 32'd1);
        end
        slot_length = 32'd1;

        // Protocol error is sticky
        empty = 4'hF;
        do_reset(2'd0);
        done = 1'b1;
        tick();
        check_eq("perr_set", {31'd0, protocol_error}, 32'd1);
        repeat (3) tick();
        check_eq("perr_sticky", {31'd0, protocol_error}, 32'd1);

        // Reset with three transactions in flight
        empty = 4'h0; grant_ready = 1'b1;
        do_reset(2'd0);
        repeat (8) tick();
        check_eq("mid_outstanding", {30'd0, outstanding}, 32'd3);
        cons_q.delete();
        empty = 4'hF;
        reset = 1'b0;
        tick();
        check_eq("mid_rst_outstanding", {30'd0, outstanding}, 32'd0);
        check_eq("mid_rst_valid", {31'd0, grant_valid}, 32'd0);
        reset = 1'b1;
        repeat (3) tick();
        check_eq("mid_no_consumed", cons_q.size(), 0);
        check_eq("mid_outstanding_after", {30'd0, outstanding}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
